// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module     : vga_timing_pkg
// Description: Default 1280x720@60 raster constants, axis total helper and
//              the per-axis phase encoding shared by the VGA timing blocks.
// Revision   : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int c_cnt_w    = 12;

    localparam int c_h_active = 1280;
    localparam int c_h_fp     = 110;
    localparam int c_h_sync   = 40;
    localparam int c_h_bp     = 220;

    localparam int c_v_active = 720;
    localparam int c_v_fp     = 5;
    localparam int c_v_sync   = 5;
    localparam int c_v_bp     = 20;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int c_h_total = axis_total(c_h_active, c_h_fp, c_h_sync, c_h_bp);
    localparam int c_v_total = axis_total(c_v_active, c_v_fp, c_v_sync, c_v_bp);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module     : vga_axis_counter
// Description: One raster axis: wrapping position counter plus the
//              ACTIVE->FRONT->SYNC->BACK phase machine that tracks it.
// Revision   : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int CNT_W  = c_cnt_w,
    parameter int ACTIVE = c_h_active,
    parameter int FP     = c_h_fp,
    parameter int SYNC   = c_h_sync,
    parameter int BP     = c_h_bp
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output phase_t           phase_nxt,
    output logic             wrap
);

    localparam int c_total = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CNT_W-1:0] c_last_active = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] c_last_front  = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] c_last_sync   = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] c_last        = CNT_W'(c_total - 1);

    logic [CNT_W-1:0] r_count;
    phase_t           r_phase;
    phase_t           w_phase_nxt;
    logic             w_wrap;

    // Phase follows the counter: it moves on when the counter leaves the
    // last index of the current phase, so no range comparators are needed.
    always_comb begin
        w_phase_nxt = r_phase;
        if (step) begin
            case (r_phase)
                PH_ACTIVE: if (r_count == c_last_active) w_phase_nxt = PH_FRONT;
                PH_FRONT:  if (r_count == c_last_front)  w_phase_nxt = PH_SYNC;
                PH_SYNC:   if (r_count == c_last_sync)   w_phase_nxt = PH_BACK;
                PH_BACK:   if (r_count == c_last)        w_phase_nxt = PH_ACTIVE;
                default:   w_phase_nxt = PH_BACK;
            endcase
        end
    end

    assign w_wrap = step && (r_count == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= c_last;
            r_phase <= PH_BACK;
        end else begin
            if (step) begin
                r_count <= w_wrap ? '0 : r_count + 1'b1;
            end
            r_phase <= w_phase_nxt;
        end
    end

    assign count     = r_count;
    assign phase_nxt = w_phase_nxt;
    assign wrap      = w_wrap;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module     : vga_timing_gen
// Description: Raster timing source: h/v counters, sync pulses, data enable,
//              frame-start strobe. Define VGA_FRAME_COUNT_EN to add the
//              16-bit frame_count output.
// Revision   : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CNT_W      = c_cnt_w,
    parameter int H_ACTIVE   = c_h_active,
    parameter int H_FP       = c_h_fp,
    parameter int H_SYNC     = c_h_sync,
    parameter int H_BP       = c_h_bp,
    parameter int V_ACTIVE   = c_v_active,
    parameter int V_FP       = c_v_fp,
    parameter int V_SYNC     = c_v_sync,
    parameter int V_BP       = c_v_bp,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] h_counter,
    output logic [CNT_W-1:0] v_counter,
    output logic             h_sync,
    output logic             v_sync,
    output logic             de,
    output logic             frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    localparam int c_h_total_p = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total_p = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if ((c_h_total_p > (1 << CNT_W)) || (c_v_total_p > (1 << CNT_W))) begin : g_cnt_w_check
            $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds 2**CNT_W");
        end
    endgenerate

    phase_t w_h_phase_nxt;
    phase_t w_v_phase_nxt;
    logic   w_h_wrap;
    logic   w_v_wrap;

    logic   r_de;
    logic   r_h_sync;
    logic   r_v_sync;
    logic   r_frame_start;

    vga_axis_counter #(
        .CNT_W  (CNT_W),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .step      (pix_ce),
        .count     (h_counter),
        .phase_nxt (w_h_phase_nxt),
        .wrap      (w_h_wrap)
    );

    // The h wrap already carries pix_ce, so the v axis steps once per line.
    vga_axis_counter #(
        .CNT_W  (CNT_W),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .step      (w_h_wrap),
        .count     (v_counter),
        .phase_nxt (w_v_phase_nxt),
        .wrap      (w_v_wrap)
    );

    // Decoding from next phases keeps every flag aligned with the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_de          <= 1'b0;
            r_h_sync      <= ~H_SYNC_POL;
            r_v_sync      <= ~V_SYNC_POL;
            r_frame_start <= 1'b0;
        end else begin
            r_de          <= (w_h_phase_nxt == PH_ACTIVE) && (w_v_phase_nxt == PH_ACTIVE);
            r_h_sync      <= (w_h_phase_nxt == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            r_v_sync      <= (w_v_phase_nxt == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
            r_frame_start <= w_v_wrap;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_count <= 16'd0;
        end else if (w_v_wrap) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

    assign de          = r_de;
    assign h_sync      = r_h_sync;
    assign v_sync      = r_v_sync;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
